// File: rtl/dlsc_demosaic_vng6_seq.sv
// Slot sequencer for the VNG6 demosaic datapath: one pixel slot of STATES cycles, 2 flush slots per row.
// Latency: st is registered (advances one cycle after a dp_en=1 edge); all other outputs are combinational.
// Backpressure: input starvation at st==0 or out_ready=0 at st==STATES-1 drops dp_en and freezes everything.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_valid / in_ready     : input column handshake (transfer in the same cycle as push)
//   out_valid / out_ready   : completed-pixel handshake, out_last marks the last pixel of a row
//   dp_en                   : datapath clock enable for every shift register
//   st, push, pad           : sub-state index, shift-register push strobe, flush-push select
//   stall_count             : stalled-cycle counter, live only when DLSC_DEMOSAIC_VNG6_SEQ_STATS_EN
//                             is defined, otherwise tied to 0

module dlsc_demosaic_vng6_seq #(
  parameter int STATES = 12,
  parameter int WIDTH  = 1024,
  parameter int XB     = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic        out_last,
  output logic        dp_en,
  output logic [3:0]  st,
  output logic        push,
  output logic        pad,
  output logic [31:0] stall_count
);

  localparam logic [3:0]    ST_LAST = 4'(STATES - 1);
  localparam logic [XB-1:0] X_PAD0  = XB'(WIDTH);
  localparam logic [XB-1:0] X_PAD1  = XB'(WIDTH + 1);
  localparam logic [XB-1:0] X_OUT0  = XB'(2);

  logic [XB-1:0] x;
  logic          st_first;
  logic          st_last;
  logic          in_slot;

  assign st_first = (st == 4'd0);
  assign st_last  = (st == ST_LAST);
  assign in_slot  = (x < X_PAD0);

  assign in_ready  = st_first && in_slot;
  assign push      = st_first && (!in_slot || in_valid);
  assign pad       = st_first && !in_slot;
  // The pipeline is two slots deep, so the first completed pixel appears in slot x=2.
  assign out_valid = st_last && (x >= X_OUT0);
  assign out_last  = out_valid && (x == X_PAD1);
  // Input and output stalls sit in different sub-states, so at most one applies.
  assign dp_en     = !((st_first && in_slot && !in_valid) || (out_valid && !out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= 4'd0;
      x  <= '0;
    end else if (dp_en) begin
      if (st_last) begin
        st <= 4'd0;
        x  <= (x == X_PAD1) ? '0 : x + XB'(1);
      end else begin
        st <= st + 4'd1;
      end
    end
  end

`ifdef DLSC_DEMOSAIC_VNG6_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= 32'd0;
    end else if (!dp_en && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_dlsc_demosaic_vng6_seq.sv
module tb_dlsc_demosaic_vng6_seq;

  localparam int STATES = 3;
  localparam int WIDTH  = 4;
  localparam int XB     = 3;

`ifdef DLSC_DEMOSAIC_VNG6_SEQ_STATS_EN
  localparam logic [31:0] EXP_STALL = 32'd9;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_last, dp_en, push, pad;
  logic [3:0]  st;
  logic [31:0] stall_count;
  logic [5:0]  flags;

  always #5 clk = ~clk;

  dlsc_demosaic_vng6_seq #(.STATES(STATES), .WIDTH(WIDTH), .XB(XB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_last(out_last),
    .dp_en(dp_en), .st(st), .push(push), .pad(pad),
    .stall_count(stall_count)
  );

  // {push, pad, in_ready, out_valid, out_last, dp_en}
  assign flags = {push, pad, in_ready, out_valid, out_last, dp_en};

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic       iv;
    logic       orr;
    logic [3:0] st;
    logic [5:0] f;
  } vec_t;

  vec_t tv[$];
  logic [5:0] rowf [18];

  function automatic void add(input logic iv, input logic orr, input logic [3:0] s, input logic [5:0] f);
    vec_t v;
    v.iv = iv; v.orr = orr; v.st = s; v.f = f;
    tv.push_back(v);
  endfunction

  function automatic void add_n(input int n, input logic iv, input logic orr, input logic [3:0] s, input logic [5:0] f);
    for (int i = 0; i < n; i++) add(iv, orr, s, f);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input int lo, input int hi, input string tag);
    for (int i = lo; i < hi; i++) begin
      in_valid  = tv[i].iv;
      out_ready = tv[i].orr;
      @(negedge clk);
      chk($sformatf("%s[%0d] st", tag, i), 32'(st), 32'(tv[i].st));
      chk($sformatf("%s[%0d] flags", tag, i), 32'(flags), 32'(tv[i].f));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // One clean row, WIDTH=4, STATES=3: slot x = c/3, st = c%3.
    rowf = '{6'b101001, 6'b000001, 6'b000001,   // x0 input
             6'b101001, 6'b000001, 6'b000001,   // x1 input
             6'b101001, 6'b000001, 6'b000101,   // x2 input, first pixel out
             6'b101001, 6'b000001, 6'b000101,   // x3 input
             6'b110001, 6'b000001, 6'b000101,   // x4 pad
             6'b110001, 6'b000001, 6'b000111};  // x5 pad, last pixel

    // Row A [0..26]: 5-cycle input starvation at x1 st0, 4-cycle backpressure on first out_valid.
    add(1, 1, 0, 6'b101001); add(1, 1, 1, 6'b000001); add(1, 1, 2, 6'b000001);
    add_n(5, 0, 1, 0, 6'b001000);
    add(1, 1, 0, 6'b101001); add(1, 1, 1, 6'b000001); add(1, 1, 2, 6'b000001);
    add(1, 1, 0, 6'b101001); add(1, 1, 1, 6'b000001);
    add_n(4, 1, 0, 2, 6'b000100);
    add(1, 1, 2, 6'b000101);
    for (int c = 9; c < 18; c++) add(1, 1, 4'(c % 3), rowf[c]);
    // Row B [27..44]: out_ready low where out_valid is not asserted must not stall.
    for (int c = 0; c < 18; c++) add(1, (c == 2) ? 1'b0 : 1'b1, 4'(c % 3), rowf[c]);
    // Row C [45..62]: in_valid low during pad slots must not stall.
    for (int c = 0; c < 18; c++) add((c < 12) ? 1'b1 : 1'b0, 1, 4'(c % 3), rowf[c]);
    // Pre-reset run [63..69]: up to x2 st0.
    for (int c = 0; c < 7; c++) add(1, 1, 4'(c % 3), rowf[c]);
    // Row D [70..87]: clean row after mid-slot reset.
    for (int c = 0; c < 18; c++) add(1, 1, 4'(c % 3), rowf[c]);

    // Reset state, observed while rst is still asserted (in_valid=0).
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset st", 32'(st), 32'd0);
    chk("reset flags", 32'(flags), 32'(6'b001000));
    chk("reset stall_count", stall_count, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run(0, 27, "rowA");
    chk("stall_count after stalls", stall_count, EXP_STALL);
    run(27, 45, "rowB");
    run(45, 63, "rowC");
    chk("stall_count after clean rows", stall_count, EXP_STALL);

    run(63, 70, "pre");
    // Now at x2 st1: reset mid-slot.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    chk("midslot st before reset", 32'(st), 32'd1);
    chk("midslot flags before reset", 32'(flags), 32'(6'b000001));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(70, 88, "rowD");
    chk("stall_count after reset", stall_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
